// File: rtl/aes_test_sequencer.sv
// Run controller for the AES verification platform: decodes UART command bytes,
// drives work/enc, bounds test campaigns and aborts stalled runs.
module aes_test_sequencer #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        vec_done,
    output logic        work,
    output logic        enc,
    output logic [31:0] limit,
    output logic [31:0] run_cnt,
    output logic        done,
    output logic        stalled,
    output logic        err_cmd
);

    if (TIMEOUT_CYC < 2 || CLK_FREQ < 1) begin : g_param_check
        $error("aes_test_sequencer: TIMEOUT_CYC must be >= 2");
    end

    localparam logic [7:0]  CMD_S   = 8'h53;
    localparam logic [7:0]  CMD_E   = 8'h45;
    localparam logic [7:0]  CMD_D   = 8'h44;
    localparam logic [7:0]  CMD_N   = 8'h4E;
    localparam logic [7:0]  CMD_P   = 8'h50;
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        LD3,
        LD2,
        LD1,
        LD0
    } state_t;

    state_t      state, state_n;
    logic [31:0] wd, wd_n;
    logic [23:0] shadow, shadow_n;
    logic        work_n, enc_n, done_n, stalled_n, err_n;
    logic [31:0] limit_n, cnt_n;

    logic        is_s, is_e, is_d, is_n, is_p;
    logic [31:0] cnt_inc;
    logic        hit;
    logic        wd_last;

    assign is_s = (rx_data == CMD_S);
    assign is_e = (rx_data == CMD_E);
    assign is_d = (rx_data == CMD_D);
    assign is_n = (rx_data == CMD_N);
    assign is_p = (rx_data == CMD_P);

    assign cnt_inc = (run_cnt == 32'hFFFF_FFFF) ? run_cnt : run_cnt + 32'd1;
    // 33-bit compare so a saturated count never matches a wrapped limit
    assign hit     = (limit != 32'd0) &&
                     (({1'b0, run_cnt} + 33'd1) == {1'b0, limit});
    assign wd_last = (wd == WD_LAST);

    always_comb begin
        state_n   = state;
        wd_n      = wd;
        shadow_n  = shadow;
        work_n    = work;
        enc_n     = enc;
        limit_n   = limit;
        cnt_n     = run_cnt;
        done_n    = 1'b0;
        stalled_n = stalled;
        err_n     = 1'b0;
        unique case (state)
            IDLE: begin
                wd_n = 32'd0;
                if (rx_valid) begin
                    unique case (1'b1)
                        is_s: begin
                            cnt_n     = 32'd0;
                            stalled_n = 1'b0;
                            work_n    = 1'b1;
                            state_n   = RUN;
                        end
                        is_e:    enc_n   = 1'b1;
                        is_d:    enc_n   = 1'b0;
                        is_n:    state_n = LD3;
                        is_p:    ;
                        default: err_n   = 1'b1;
                    endcase
                end
            end
            RUN: begin
                wd_n = wd + 32'd1;
                if (vec_done) begin
                    cnt_n = cnt_inc;
                    wd_n  = 32'd0;
                end
                if (vec_done && hit) begin
                    work_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    if (rx_valid) begin
                        unique case (1'b1)
                            is_p: begin
                                work_n  = 1'b0;
                                state_n = IDLE;
                            end
                            is_s: begin
                                cnt_n = 32'd0;
                                wd_n  = 32'd0;
                            end
                            default: err_n = 1'b1;
                        endcase
                    end
                    // a progress pulse or stop/restart byte rescues the run
                    if (!vec_done && wd_last &&
                        !(rx_valid && (is_p || is_s))) begin
                        work_n    = 1'b0;
                        stalled_n = 1'b1;
                        state_n   = IDLE;
                    end
                end
            end
            LD3, LD2, LD1, LD0: begin
                wd_n = wd + 32'd1;
                if (rx_valid) begin
                    shadow_n = {shadow[15:0], rx_data};
                    wd_n     = 32'd0;
                    unique case (state)
                        LD3:     state_n = LD2;
                        LD2:     state_n = LD1;
                        LD1:     state_n = LD0;
                        default: begin
                            limit_n = {shadow, rx_data};
                            state_n = IDLE;
                        end
                    endcase
                end else if (wd_last) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                work_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wd      <= 32'd0;
            shadow  <= 24'd0;
            work    <= 1'b0;
            enc     <= 1'b1;
            limit   <= 32'd0;
            run_cnt <= 32'd0;
            done    <= 1'b0;
            stalled <= 1'b0;
            err_cmd <= 1'b0;
        end else begin
            state   <= state_n;
            wd      <= wd_n;
            shadow  <= shadow_n;
            work    <= work_n;
            enc     <= enc_n;
            limit   <= limit_n;
            run_cnt <= cnt_n;
            done    <= done_n;
            stalled <= stalled_n;
            err_cmd <= err_n;
        end
    end

endmodule

// File: tb/tb_aes_test_sequencer.sv
// Directed bench for aes_test_sequencer with a done-pulse scoreboard.
module tb_aes_test_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        vec_done = 1'b0;
    logic        work, enc, done, stalled, err_cmd;
    logic [31:0] limit, run_cnt;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int err_seen = 0;
    logic [31:0] exp_done_q[$];

    aes_test_sequencer #(
        .CLK_FREQ(50_000_000),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .vec_done(vec_done),
        .work(work),
        .enc(enc),
        .limit(limit),
        .run_cnt(run_cnt),
        .done(done),
        .stalled(stalled),
        .err_cmd(err_cmd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // done pulses are compared against the scoreboard as they appear
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_seen++;
            if (exp_done_q.size() == 0)
                chk("done_unexpected", 32'(exp_done_q.size()), 32'd1);
            else
                chk("done_run_cnt", run_cnt, exp_done_q.pop_front());
        end
        if (rst_n && err_cmd) err_seen++;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
    endtask

    task automatic pulse();
        @(negedge clk);
        vec_done = 1'b1;
        @(negedge clk);
        vec_done = 1'b0;
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        // reset values
        wait_cyc(3);
        chk("rst_work", 32'(work), 32'd0);
        chk("rst_enc", 32'(enc), 32'd1);
        chk("rst_limit", limit, 32'd0);
        chk("rst_run_cnt", run_cnt, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stalled", 32'(stalled), 32'd0);
        chk("rst_err", 32'(err_cmd), 32'd0);
        rst_n = 1'b1;
        wait_cyc(2);

        // bounded campaign of 5 vectors
        send(8'h4E); send(8'h00); send(8'h00); send(8'h00); send(8'h05);
        chk("limit5", limit, 32'd5);
        exp_done_q.push_back(32'd5);
        send(8'h53);
        chk("work_after_s", 32'(work), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) wait_cyc(8);
            pulse();
        end
        chk("done_pulse5", 32'(done), 32'd1);
        chk("done_seen1", 32'(done_seen), 32'd1);
        chk("run_cnt5", run_cnt, 32'd5);
        chk("work_off5", 32'(work), 32'd0);
        wait_cyc(1);
        chk("done_one_cycle", 32'(done), 32'd0);

        // enc locked during run, rejected byte
        send(8'h44);
        chk("enc_d", 32'(enc), 32'd0);
        send(8'h53);
        send(8'h45);
        chk("enc_locked", 32'(enc), 32'd0);
        chk("work_kept", 32'(work), 32'd1);
        chk("err_once", 32'(err_seen), 32'd1);
        send(8'h50);
        chk("work_p", 32'(work), 32'd0);

        // watchdog abort after 100 cycles in RUN
        send(8'h53);
        wait_cyc(99);
        chk("wd_work_99", 32'(work), 32'd1);
        wait_cyc(1);
        chk("wd_work_100", 32'(work), 32'd0);
        chk("wd_stalled", 32'(stalled), 32'd1);
        chk("wd_no_done", 32'(done_seen), 32'd1);
        chk("wd_no_err", 32'(err_seen), 32'd1);
        send(8'h53);
        chk("stall_clr", 32'(stalled), 32'd0);
        send(8'h50);

        // limit load timeout
        send(8'h4E); send(8'h12); send(8'h34);
        wait_cyc(110);
        chk("ld_to_err", 32'(err_seen), 32'd2);
        chk("ld_to_limit", limit, 32'd5);
        send(8'h53);
        chk("ld_to_run", 32'(work), 32'd1);
        send(8'h50);

        // vec_done and 'S' together on the limit
        send(8'h4E); send(8'h00); send(8'h00); send(8'h00); send(8'h03);
        chk("limit3", limit, 32'd3);
        exp_done_q.push_back(32'd3);
        send(8'h53);
        pulse(); wait_cyc(2); pulse();
        chk("run_cnt2", run_cnt, 32'd2);
        @(negedge clk);
        rx_data  = 8'h53;
        rx_valid = 1'b1;
        vec_done = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        vec_done = 1'b0;
        #1;
        chk("sim_done_seen", 32'(done_seen), 32'd2);
        chk("sim_work", 32'(work), 32'd0);
        chk("sim_run_cnt", run_cnt, 32'd3);
        chk("sim_no_err", 32'(err_seen), 32'd2);

        // unlimited run, stop, then reset mid-run
        send(8'h4E); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        chk("limit0", limit, 32'd0);
        send(8'h53);
        for (int i = 0; i < 1000; i++) pulse();
        send(8'h50);
        chk("unl_run_cnt", run_cnt, 32'd1000);
        chk("unl_work", 32'(work), 32'd0);
        chk("unl_no_done", 32'(done_seen), 32'd2);
        send(8'h53);
        pulse(); pulse(); pulse();
        chk("pre_rst_cnt", run_cnt, 32'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_work", 32'(work), 32'd0);
        chk("mid_rst_enc", 32'(enc), 32'd1);
        chk("mid_rst_cnt", run_cnt, 32'd0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);

        chk("sb_empty", 32'(exp_done_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
